// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a requester and alu_cmd_sequencer.
// The master side issues commands and consumes responses; the slave side is the sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_carry;
    logic             rsp_ovf;
    logic             rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_hi, rsp_carry, rsp_ovf, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_hi, rsp_carry, rsp_ovf, rsp_zero
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer around a ripple-carry N-bit ALU: single-pass logic/arith ops
// plus an unsigned shift-add multiply that reuses the ALU adder once per bit.
module myNBitALU #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carryIn,
    input  logic             invert1,
    input  logic             invert2,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carryOut
);
    logic [WIDTH:0] carry;

    assign carry[0] = carryIn;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            logic a_bit;
            logic b_bit;
            logic sum_bit;

            assign a_bit         = in1[gi] ^ invert1;
            assign b_bit         = in2[gi] ^ invert2;
            assign sum_bit       = a_bit ^ b_bit ^ carry[gi];
            assign carry[gi+1]   = (a_bit & b_bit) | (carry[gi] & (a_bit ^ b_bit));
            assign result[gi]    = (op == 2'b00) ? (a_bit & b_bit) :
                                   (op == 2'b01) ? (a_bit | b_bit) :
                                   (op == 2'b10) ? sum_bit : 1'b0;
        end
    endgenerate

    assign carryOut = carry[WIDTH];
endmodule

module alu_cmd_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus,
    output logic                busy
);
    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] hi_acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic [WIDTH-1:0] rsp_hi_reg;
    logic             rsp_carry_reg;
    logic             rsp_ovf_reg;
    logic             rsp_zero_reg;

    logic [WIDTH-1:0] alu_in1, alu_in2, alu_result;
    logic             alu_cin, alu_inv1, alu_inv2, alu_cout;
    logic [1:0]       alu_op;

    myNBitALU #(.WIDTH(WIDTH)) u_alu (
        .in1      (alu_in1),
        .in2      (alu_in2),
        .carryIn  (alu_cin),
        .invert1  (alu_inv1),
        .invert2  (alu_inv2),
        .op       (alu_op),
        .result   (alu_result),
        .carryOut (alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; the ALU is only driven in EXEC and MUL, idle at zero otherwise.
    always_comb begin
        state_next = state_reg;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_cin    = 1'b0;
        alu_inv1   = 1'b0;
        alu_inv2   = 1'b0;
        alu_op     = 2'b00;
        case (state_reg)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_next = (bus.cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                alu_in1 = a_reg;
                alu_in2 = b_reg;
                case (op_reg)
                    OP_OR:  alu_op = 2'b01;
                    OP_ADD: alu_op = 2'b10;
                    OP_SUB, OP_SLT: begin
                        alu_inv2 = 1'b1;
                        alu_cin  = 1'b1;
                        alu_op   = 2'b10;
                    end
                    OP_NOR: begin
                        alu_inv1 = 1'b1;
                        alu_inv2 = 1'b1;
                    end
                    OP_NAND: begin
                        alu_inv1 = 1'b1;
                        alu_inv2 = 1'b1;
                        alu_op   = 2'b01;
                    end
                    default: alu_op = 2'b00;
                endcase
                state_next = S_DONE;
            end
            S_MUL: begin
                alu_in1 = hi_acc_reg;
                alu_in2 = b_reg[0] ? a_reg : '0;
                alu_op  = 2'b10;
                if (cnt_reg == LAST_ITER) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_valid_reg && bus.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Flags are derived from the effective (post-inversion) operand sign bits.
    logic             is_arith;
    logic             a_msb, b_msb, sum_msb, ovf;
    logic [WIDTH-1:0] exec_result;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

    assign is_arith    = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_SLT);
    assign a_msb       = alu_in1[WIDTH-1] ^ alu_inv1;
    assign b_msb       = alu_in2[WIDTH-1] ^ alu_inv2;
    assign sum_msb     = alu_result[WIDTH-1];
    assign ovf         = (a_msb == b_msb) && (sum_msb != a_msb);
    assign exec_result = (op_reg == OP_SLT) ? {{(WIDTH-1){1'b0}}, sum_msb ^ ovf} : alu_result;
    assign mul_hi_next = {alu_cout, alu_result[WIDTH-1:1]};
    assign mul_lo_next = {alu_result[0], b_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            hi_acc_reg     <= '0;
            cnt_reg        <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_hi_reg     <= '0;
            rsp_carry_reg  <= 1'b0;
            rsp_ovf_reg    <= 1'b0;
            rsp_zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_reg     <= bus.cmd_op;
                        a_reg      <= bus.cmd_a;
                        b_reg      <= bus.cmd_b;
                        hi_acc_reg <= '0;
                        cnt_reg    <= '0;
                    end
                end
                S_EXEC: begin
                    rsp_result_reg <= exec_result;
                    rsp_hi_reg     <= '0;
                    rsp_carry_reg  <= is_arith & alu_cout;
                    rsp_ovf_reg    <= is_arith & ovf;
                    rsp_zero_reg   <= (exec_result == '0);
                end
                S_MUL: begin
                    // b_reg doubles as the low product half, shifting in sum bits.
                    hi_acc_reg <= mul_hi_next;
                    b_reg      <= mul_lo_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        rsp_result_reg <= mul_lo_next;
                        rsp_hi_reg     <= mul_hi_next;
                        rsp_carry_reg  <= 1'b0;
                        rsp_ovf_reg    <= 1'b0;
                        rsp_zero_reg   <= (mul_hi_next == '0) && (mul_lo_next == '0);
                    end
                end
                S_DONE: begin
                    if (!rsp_valid_reg) begin
                        rsp_valid_reg <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: rsp_valid_reg <= 1'b0;
            endcase
        end
    end

    assign bus.cmd_ready  = (state_reg == S_IDLE);
    assign busy           = (state_reg != S_IDLE);
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_hi     = rsp_hi_reg;
    assign bus.rsp_carry  = rsp_carry_reg;
    assign bus.rsp_ovf    = rsp_ovf_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer (WIDTH=32): hand-computed vectors for each op,
// latency, backpressure hold, back-to-back acceptance and reset during a multiply.
module tb_alu_cmd_sequencer;
    localparam int W = 32;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_vec;
    int   n_err;

    alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

    alu_cmd_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard         = 0;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk("accept_ready", {63'd0, bus.cmd_ready}, 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output bit ready_seen);
        lat        = 0;
        ready_seen = 1'b0;
        while (bus.rsp_valid !== 1'b1 && lat < 100) begin
            if (bus.cmd_ready !== 1'b0) ready_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [W-1:0] res, input logic [W-1:0] hi,
                             input logic c, input logic o, input logic z);
        chk({tag, "_result"}, {32'd0, bus.rsp_result}, {32'd0, res});
        chk({tag, "_hi"},     {32'd0, bus.rsp_hi},     {32'd0, hi});
        chk({tag, "_carry"},  {63'd0, bus.rsp_carry},  {63'd0, c});
        chk({tag, "_ovf"},    {63'd0, bus.rsp_ovf},    {63'd0, o});
        chk({tag, "_zero"},   {63'd0, bus.rsp_zero},   {63'd0, z});
        $display("txn %s: result=%h hi=%h carry=%0b ovf=%0b zero=%0b", tag,
                 bus.rsp_result, bus.rsp_hi, bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero);
    endtask

    task automatic drain(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_drain_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
        chk({tag, "_drain_busy"},  {63'd0, busy},          64'd0);
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] res,
                          input logic [W-1:0] hi, input logic c, input logic o, input logic z);
        int lat;
        bit rdy;
        issue(op, a, b);
        wait_rsp(lat, rdy);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_ready_low"}, {63'd0, rdy}, 64'd0);
        check_rsp(tag, res, hi, c, o, z);
        drain(tag);
    endtask

    initial begin
        int lat;
        bit rdy;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        chk("rst_busy",      {63'd0, busy},          64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_result",    {32'd0, bus.rsp_result}, 64'd0);
        chk("rst_zero",      {63'd0, bus.rsp_zero},  64'd0);
        rst_n = 1'b1;
        tick();

        do_cmd("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 2, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0);
        do_cmd("sub_eq",    OP_SUB, 32'h00000005, 32'h00000005, 2, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1);
        do_cmd("sub_borrow",OP_SUB, 32'h00000000, 32'h00000001, 2, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        do_cmd("slt_neg",   OP_SLT, 32'hFFFFFFFF, 32'h00000001, 2, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b0);
        do_cmd("slt_ovf1",  OP_SLT, 32'h80000000, 32'h7FFFFFFF, 2, 32'h00000001, 32'h0, 1'b1, 1'b1, 1'b0);
        do_cmd("slt_ovf0",  OP_SLT, 32'h7FFFFFFF, 32'h80000000, 2, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b1);
        do_cmd("mul_max",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        do_cmd("mul_zero",  OP_MUL, 32'h00000000, 32'h00001234, 33, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b1);
        do_cmd("mul_hi",    OP_MUL, 32'h00010000, 32'h00010000, 33, 32'h00000000, 32'h1, 1'b0, 1'b0, 1'b0);
        do_cmd("add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 2, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1);

        // Backpressure with the next command already waiting on the bus.
        issue(OP_AND, 32'h0000000F, 32'h0000000A);
        wait_rsp(lat, rdy);
        chk("bp_latency", 64'(lat), 64'd2);
        bus.cmd_op    = OP_OR;
        bus.cmd_a     = 32'h0000000F;
        bus.cmd_b     = 32'h0000000A;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_result",    {32'd0, bus.rsp_result}, 64'h0000000A);
            chk("bp_valid",     {63'd0, bus.rsp_valid},  64'd1);
            chk("bp_cmd_ready", {63'd0, bus.cmd_ready},  64'd0);
            tick();
        end
        $display("txn bp_and: result=%h held through backpressure", bus.rsp_result);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_drain_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("bp_idle_ready",  {63'd0, bus.cmd_ready}, 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_rsp(lat, rdy);
        chk("b2b_latency", 64'(lat), 64'd2);
        check_rsp("b2b_or", 32'h0000000F, 32'h0, 1'b0, 1'b0, 1'b0);
        drain("b2b_or");

        // Reset during MUL iteration 10.
        issue(OP_MUL, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) tick();
        chk("mul_busy_pre_rst", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_mid_busy",  {63'd0, busy},          64'd0);
        chk("rst_mid_ready", {63'd0, bus.cmd_ready}, 64'd1);
        $display("txn rst_mid_mul: aborted, busy=%0b rsp_valid=%0b", busy, bus.rsp_valid);
        #2;
        rst_n = 1'b1;
        tick();

        do_cmd("nor",  OP_NOR,  32'h0000000F, 32'h0000000A, 2, 32'hFFFFFFF0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_cmd("nand", OP_NAND, 32'h0FFFFFFF, 32'hF0000000, 2, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
